// File: rtl/addr_dec_pkg.sv
// Shared types and default sizing for the serial address decoder.
package addr_dec_pkg;

  localparam int DEF_ADDR_WIDTH  = 16;
  localparam int DEF_NUM_TARGETS = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ADDR   = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_SPLIT  = 2'd3
  } dec_state_e;

endpackage

// File: rtl/addr_decoder_n_shift.sv
// LSB-first deserialiser: start loads bit 0, shift places the next bit at the
// running count, done flags the shift that completes the word.
module serial_shift_in #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             start,
  input  logic             shift,
  input  logic             bit_in,
  output logic [WIDTH-1:0] shift_word,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] data_r;
  logic [CNT_W-1:0] count_r;

  // word as it looks once the current bit is placed; done on the final bit
  always_comb begin
    done = shift && (count_r == CNT_W'(WIDTH - 1));
    for (int k = 0; k < WIDTH; k++) begin
      shift_word[k] = (count_r == CNT_W'(k)) ? bit_in : data_r[k];
    end
  end

  // shift register and bit counter; a completed word frees the register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_r  <= '0;
      count_r <= '0;
    end else if (clear || done) begin
      data_r  <= '0;
      count_r <= '0;
    end else if (start) begin
      data_r  <= {{(WIDTH-1){1'b0}}, bit_in};
      count_r <= CNT_W'(1);
    end else if (shift) begin
      data_r  <= shift_word;
      count_r <= count_r + CNT_W'(1);
    end
  end

endmodule

// File: rtl/addr_decoder_n.sv
// Serial address decoder: collects an LSB-first address, decodes its top bits
// into a one-hot target select and tracks split / release of the transaction.
module addr_decoder_n
  import addr_dec_pkg::*;
#(
  parameter  int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter  int NUM_TARGETS = DEF_NUM_TARGETS,
  localparam int TGT_BITS    = (NUM_TARGETS > 2) ? $clog2(NUM_TARGETS) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   bus_data_in,
  input  logic                   bus_data_in_valid,
  input  logic                   bus_mode,
  input  logic                   split,
  input  logic                   txn_end,
  output logic [NUM_TARGETS-1:0] target_valid,
  output logic [TGT_BITS-1:0]    sel,
  output logic [ADDR_WIDTH-1:0]  addr_out,
  output logic                   addr_valid,
  output logic                   decode_err,
  output logic                   split_pending
);

  localparam int            NT_I = NUM_TARGETS;
  localparam logic [TGT_BITS:0] NT_L = NT_I[TGT_BITS:0];

  dec_state_e state_r, state_s;

  logic                   bit_ok_s, start_s, shift_s, clear_s, done_s, idx_ok_s;
  logic [ADDR_WIDTH-1:0]  word_s;
  logic [TGT_BITS-1:0]    idx_s;

  logic [NUM_TARGETS-1:0] tv_s, tv_r;
  logic [TGT_BITS-1:0]    sel_s, sel_r;
  logic [ADDR_WIDTH-1:0]  aout_s, aout_r;
  logic                   av_s, av_r, de_s, de_r, sp_s, sp_r;

  function automatic logic [NUM_TARGETS-1:0] onehot(input logic [TGT_BITS-1:0] i);
    logic [NUM_TARGETS-1:0] r;
    for (int k = 0; k < NUM_TARGETS; k++) begin
      r[k] = (i == TGT_BITS'(k));
    end
    return r;
  endfunction

  assign bit_ok_s = bus_data_in_valid && bus_mode;
  assign start_s  = bit_ok_s && ((state_r == ST_IDLE) ||
                                 ((state_r == ST_ACTIVE) && !txn_end && !split));
  assign shift_s  = (state_r == ST_ADDR) && bit_ok_s;
  assign clear_s  = (state_r == ST_ADDR) && !bus_mode;
  assign idx_s    = word_s[ADDR_WIDTH-1 -: TGT_BITS];
  assign idx_ok_s = ({1'b0, idx_s} < NT_L);

  serial_shift_in #(.WIDTH(ADDR_WIDTH)) u_shift (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear_s),
    .start      (start_s),
    .shift      (shift_s),
    .bit_in     (bus_data_in),
    .shift_word (word_s),
    .done       (done_s)
  );

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // next state; txn_end outranks split, split outranks a new address
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bit_ok_s) state_s = ST_ADDR;
        else          state_s = ST_IDLE;
      end
      ST_ADDR: begin
        if (!bus_mode)                 state_s = ST_IDLE;
        else if (done_s && idx_ok_s)   state_s = ST_ACTIVE;
        else if (done_s)               state_s = ST_IDLE;
        else                           state_s = ST_ADDR;
      end
      ST_ACTIVE: begin
        if (txn_end)       state_s = ST_IDLE;
        else if (split)    state_s = ST_SPLIT;
        else if (bit_ok_s) state_s = ST_ADDR;
        else               state_s = ST_ACTIVE;
      end
      ST_SPLIT: begin
        if (txn_end)     state_s = ST_IDLE;
        else if (!split) state_s = ST_ACTIVE;
        else             state_s = ST_SPLIT;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // next values of the registered outputs
  always_comb begin
    tv_s   = tv_r;
    sel_s  = sel_r;
    aout_s = aout_r;
    av_s   = 1'b0;
    de_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        tv_s = tv_r;
      end
      ST_ADDR: begin
        if (!bus_mode) begin
          de_s = 1'b1;
        end else if (done_s && idx_ok_s) begin
          tv_s   = onehot(idx_s);
          sel_s  = idx_s;
          aout_s = word_s;
          av_s   = 1'b1;
        end else if (done_s) begin
          tv_s   = '0;
          aout_s = word_s;
          de_s   = 1'b1;
        end else begin
          tv_s = tv_r;
        end
      end
      ST_ACTIVE: begin
        if (txn_end) begin
          tv_s  = '0;
          sel_s = '0;
        end else if (split || bit_ok_s) begin
          tv_s = '0;
        end else begin
          tv_s = tv_r;
        end
      end
      ST_SPLIT: begin
        if (txn_end) begin
          tv_s  = '0;
          sel_s = '0;
        end else if (!split) begin
          tv_s = onehot(sel_r);
        end else begin
          tv_s = tv_r;
        end
      end
      default: begin
        tv_s  = '0;
        sel_s = '0;
      end
    endcase
    sp_s = (state_s == ST_SPLIT);
  end

  // output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tv_r   <= '0;
      sel_r  <= '0;
      aout_r <= '0;
      av_r   <= 1'b0;
      de_r   <= 1'b0;
      sp_r   <= 1'b0;
    end else begin
      tv_r   <= tv_s;
      sel_r  <= sel_s;
      aout_r <= aout_s;
      av_r   <= av_s;
      de_r   <= de_s;
      sp_r   <= sp_s;
    end
  end

  assign target_valid  = tv_r;
  assign sel           = sel_r;
  assign addr_out      = aout_r;
  assign addr_valid    = av_r;
  assign decode_err    = de_r;
  assign split_pending = sp_r;

endmodule

// File: tb/tb_addr_decoder_n.sv
// Bench for addr_decoder_n (16-bit address, 3 targets): directed table,
// hand-written split/abort/reset sequences and a randomized model comparison.
module tb_addr_decoder_n;

  localparam int AW = 16;
  localparam int NT = 3;
  localparam int TB = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic bus_data_in = 1'b0, bus_data_in_valid = 1'b0, bus_mode = 1'b0;
  logic split = 1'b0, txn_end = 1'b0;
  logic [NT-1:0] target_valid;
  logic [TB-1:0] sel;
  logic [AW-1:0] addr_out;
  logic addr_valid, decode_err, split_pending;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  addr_decoder_n #(.ADDR_WIDTH(AW), .NUM_TARGETS(NT)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .bus_data_in       (bus_data_in),
    .bus_data_in_valid (bus_data_in_valid),
    .bus_mode          (bus_mode),
    .split             (split),
    .txn_end           (txn_end),
    .target_valid      (target_valid),
    .sel               (sel),
    .addr_out          (addr_out),
    .addr_valid        (addr_valid),
    .decode_err        (decode_err),
    .split_pending     (split_pending)
  );

  typedef struct {
    logic [AW-1:0] addr;
    int            stall_at;
    logic [NT-1:0] tv;
    logic [TB-1:0] sel;
    logic          err;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic drive(input logic v, input logic m, input logic b,
                       input logic sp, input logic te);
    bus_data_in_valid = v;
    bus_mode          = m;
    bus_data_in       = b;
    split             = sp;
    txn_end           = te;
    @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [AW-1:0] a, input int nbits, input int stall_at);
    for (int i = 0; i < nbits; i++) begin
      if (i == stall_at) begin
        repeat (3) drive(1'b0, 1'b1, ~a[i], 1'b0, 1'b0);
        chk("stall_no_pulse", {addr_valid, decode_err}, 2'b00);
      end
      drive(1'b1, 1'b1, a[i], 1'b0, 1'b0);
      if (i == AW - 2) chk("early_no_pulse", {addr_valid, decode_err}, 2'b00);
    end
  endtask

  task automatic check_all_zero(input string nm);
    chk(nm, {target_valid, sel, addr_out, addr_valid, decode_err, split_pending}, 32'h0);
  endtask

  // ---------------- reference model: rules of the decoder in plain arithmetic
  localparam int M_IDLE = 0, M_ADDR = 1, M_ACTIVE = 2, M_SPLIT = 3;
  int            m_phase;
  int unsigned   m_acc, m_nbits, m_idx;
  logic [NT-1:0] m_tv;
  logic [TB-1:0] m_sel;
  logic [AW-1:0] m_aout;
  logic          m_av, m_de, m_sp;

  task automatic model_reset();
    m_phase = M_IDLE; m_acc = 0; m_nbits = 0;
    m_tv = '0; m_sel = '0; m_aout = '0; m_av = 1'b0; m_de = 1'b0; m_sp = 1'b0;
  endtask

  task automatic model_step(input logic v, input logic m, input logic b,
                            input logic sp, input logic te);
    m_av = 1'b0;
    m_de = 1'b0;
    if (m_phase == M_IDLE) begin
      if (v && m) begin m_acc = 32'(b); m_nbits = 1; m_phase = M_ADDR; end
    end else if (m_phase == M_ADDR) begin
      if (!m) begin
        m_de = 1'b1; m_acc = 0; m_nbits = 0; m_phase = M_IDLE;
      end else if (v) begin
        m_acc = m_acc + (32'(b) << m_nbits);
        m_nbits++;
        if (m_nbits == AW) begin
          m_aout = m_acc[AW-1:0];
          m_idx  = m_acc >> (AW - TB);
          if (m_idx < NT) begin
            m_tv = NT'(1 << m_idx); m_sel = TB'(m_idx); m_av = 1'b1; m_phase = M_ACTIVE;
          end else begin
            m_tv = '0; m_de = 1'b1; m_phase = M_IDLE;
          end
          m_acc = 0; m_nbits = 0;
        end
      end
    end else if (m_phase == M_ACTIVE) begin
      if (te) begin m_tv = '0; m_sel = '0; m_phase = M_IDLE; end
      else if (sp) begin m_tv = '0; m_phase = M_SPLIT; end
      else if (v && m) begin m_tv = '0; m_acc = 32'(b); m_nbits = 1; m_phase = M_ADDR; end
    end else begin
      if (te) begin m_tv = '0; m_sel = '0; m_phase = M_IDLE; end
      else if (!sp) begin m_tv = NT'(1 << m_sel); m_phase = M_ACTIVE; end
    end
    m_sp = (m_phase == M_SPLIT);
  endtask

  vec_t vt[5];

  initial begin
    vt[0] = '{16'h800A, -1, 3'b100, 2'd2, 1'b0};
    vt[1] = '{16'hC000, -1, 3'b000, 2'd0, 1'b1};
    vt[2] = '{16'h4001,  6, 3'b010, 2'd1, 1'b0};
    vt[3] = '{16'h0005, -1, 3'b001, 2'd0, 1'b0};
    vt[4] = '{16'hFFFF,  3, 3'b000, 2'd0, 1'b1};

    #12;
    check_all_zero("reset_state");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // directed table
    for (int i = 0; i < 5; i++) begin
      send_bits(vt[i].addr, AW, vt[i].stall_at);
      chk("tbl_target_valid", target_valid, vt[i].tv);
      chk("tbl_sel", sel, vt[i].sel);
      chk("tbl_addr_out", addr_out, vt[i].addr);
      chk("tbl_addr_valid", addr_valid, !vt[i].err);
      chk("tbl_decode_err", decode_err, vt[i].err);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("tbl_pulse_end", {addr_valid, decode_err}, 2'b00);
      chk("tbl_tv_held", target_valid, vt[i].tv);
      if (vt[i].err) begin
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("tbl_err_idle", {split_pending, target_valid}, 4'b0);
      end
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("tbl_release", {target_valid, sel, split_pending}, 6'b0);
    end

    // abort after 9 bits, then a clean decode with data-phase bits ignored
    send_bits(16'h4001, 9, -1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("abort_err", {decode_err, addr_valid, target_valid}, 5'b10000);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("abort_pulse_end", decode_err, 1'b0);
    send_bits(16'h0005, AW, -1);
    chk("after_abort_tv", {target_valid, sel, addr_valid}, 6'b001_00_1);
    repeat (3) drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("data_phase_ignored", {target_valid, sel}, 5'b001_00);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // split, resume, release; then split+txn_end together and txn_end in SPLIT
    send_bits(16'h800A, AW, -1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("split_enter", {target_valid, split_pending, sel}, 6'b000_1_10);
    chk("split_addr_kept", addr_out, 16'h800A);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("split_ignores_bus", {target_valid, split_pending}, 4'b000_1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("split_resume", {target_valid, split_pending, addr_valid}, 5'b100_0_0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("split_release", {target_valid, sel, split_pending}, 6'b0);
    send_bits(16'h800A, AW, -1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("txn_end_wins", {target_valid, sel, split_pending}, 6'b0);
    send_bits(16'h800A, AW, -1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("split_txn_end", {target_valid, sel, split_pending}, 6'b0);

    // asynchronous reset mid-address, then a fresh decode
    send_bits(16'h800A, AW, -1);
    send_bits(16'h1234, 8, -1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    send_bits(16'h800A, AW, -1);
    chk("post_reset_decode", {target_valid, sel, addr_valid}, 6'b100_10_1);
    chk("post_reset_addr", addr_out, 16'h800A);

    // randomized run against the model
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    model_reset();
    rst_n = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      logic v, m, b, sp, te;
      v  = ($urandom_range(0, 9) != 0);
      m  = ($urandom_range(0, 39) != 0);
      b  = 1'($urandom_range(0, 1));
      sp = ($urandom_range(0, 11) == 0);
      te = ($urandom_range(0, 29) == 0);
      bus_data_in_valid = v; bus_mode = m; bus_data_in = b; split = sp; txn_end = te;
      @(posedge clk);
      model_step(v, m, b, sp, te);
      #1;
      chk("random_outputs",
          {target_valid, sel, addr_out, addr_valid, decode_err, split_pending},
          {m_tv, m_sel, m_aout, m_av, m_de, m_sp});
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/addr_decoder_n.md
ADDR_DECODER_N -- requirements
Module: addr_decoder_n

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, serial address length in bits (legal 8..32).
REQ-002 SHALL have parameter NUM_TARGETS, default 3, number of decoded targets (legal 2..8).
REQ-003 SHALL derive localparam TGT_BITS = max(1, clog2(NUM_TARGETS)); ADDR_WIDTH > TGT_BITS.
REQ-004 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port bus_data_in  input  1  serial bus bit, LSB first.
REQ-007 SHALL have port bus_data_in_valid  input  1  bus_data_in qualifier; low = stall, bit ignored.
REQ-008 SHALL have port bus_mode  input  1  1 = address phase, 0 = data phase.
REQ-009 SHALL have port split  input  1  selected target has split the transaction.
REQ-010 SHALL have port txn_end  input  1  single-cycle pulse, transaction complete / bus released.
REQ-011 SHALL have port target_valid  output  NUM_TARGETS  one-hot select of decoded target.
REQ-012 SHALL have port sel  output  TGT_BITS  index of decoded target (read-mux select).
REQ-013 SHALL have port addr_out  output  ADDR_WIDTH  last fully received address.
REQ-014 SHALL have port addr_valid  output  1  one-cycle pulse, addr_out/sel newly decoded.
REQ-015 SHALL have port decode_err  output  1  one-cycle pulse, unmapped or aborted address.
REQ-016 SHALL have port split_pending  output  1  high while in SPLIT.

Function
REQ-017 SHALL implement FSM IDLE, ADDR, ACTIVE, SPLIT.
REQ-018 IDLE: valid&&bus_mode SHALL shift bit 0, bit count=1, go ADDR; otherwise stay.
REQ-019 ADDR: each valid&&bus_mode cycle SHALL shift next bit into position count, count+1; valid low SHALL hold state and count.
REQ-020 Decode index SHALL be addr[ADDR_WIDTH-1 -: TGT_BITS] of the completed address.
REQ-021 On the edge sampling bit ADDR_WIDTH-1: index<NUM_TARGETS -> target_valid=1<<index, sel=index, addr_out loaded, addr_valid=1 for one cycle, go ACTIVE; outputs visible the cycle after last bit (latency 1).
REQ-022 Same edge, index>=NUM_TARGETS -> decode_err=1 one cycle, addr_out loaded, target_valid=0, go IDLE.
REQ-023 ADDR: bus_mode=0 before count reaches ADDR_WIDTH SHALL abort: decode_err pulse, go IDLE, outputs unchanged.
REQ-024 ACTIVE: target_valid and sel held; data-phase bits (bus_mode=0) ignored.
REQ-025 ACTIVE: txn_end SHALL clear target_valid, sel=0, go IDLE next cycle.
REQ-026 ACTIVE: split=1 (no txn_end) SHALL go SPLIT, clear target_valid, retain sel and addr_out, split_pending=1.
REQ-027 ACTIVE: txn_end and split same cycle -> txn_end wins.
REQ-028 ACTIVE: valid&&bus_mode SHALL start a new transaction: clear target_valid, capture bit 0, count=1, go ADDR.
REQ-029 SPLIT: all bus bits ignored; split=0 -> ACTIVE with target_valid=1<<sel re-asserted, no addr_valid pulse.
REQ-030 SPLIT: txn_end SHALL go IDLE, clear split_pending, sel=0.
REQ-031 target_valid SHALL never have more than one bit set.

Reset
REQ-032 rst_n low SHALL asynchronously force state IDLE, count 0, shift register 0, target_valid 0, sel 0, addr_out 0, addr_valid 0, decode_err 0, split_pending 0.
REQ-033 Reset mid-ADDR SHALL discard partial address; first valid address bit after release starts a fresh decode.

Structure
REQ-034 Package addr_dec_pkg SHALL hold the FSM state enum and default ADDR_WIDTH/NUM_TARGETS constants.
REQ-035 Sub-module serial_shift_in (parametrised width; shift, count, done flag, clear) SHALL implement the deserialiser.

Verification
REQ-036 16/3 config: serial 16'h800A, valid continuous -> cycle after bit 15: target_valid=3'b100, sel=2'b10, addr_out=16'h800A, addr_valid one pulse.
REQ-037 Serial 16'hC000 -> decode_err one pulse, target_valid=0, state IDLE.
REQ-038 16'h4001 with valid low 3 cycles mid-stream -> target_valid=3'b010, sel=2'b01, latency 1 after final bit.
REQ-039 bus_mode drops after 9 bits -> decode_err pulse, no target_valid; then 16'h0005 -> target_valid=3'b001.
REQ-040 After 16'h800A decode: split=1 -> target_valid=0, split_pending=1; split=0 -> target_valid=3'b100 again; txn_end -> all 0; split+txn_end together -> IDLE.
REQ-041 rst_n low after 8 address bits -> all outputs 0 asynchronously; re-send 16'h800A -> correct decode.
